// File: rtl/clk_mon_pkg.sv
// Shared definitions for the clock frequency monitor.
//   state_t  : measurement FSM states
//   CNT_W    : width of the edge counter and Count_Value
//   CNT_SAT  : saturation value of the edge counter
//   GATE_W() : gate counter width for a given window length
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    EVAL    = 2'd3
  } state_t;

  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

  // Gate counter only has to hold 0..gate_cycles-1.
  function automatic int GATE_W(input int gate_cycles);
    return (gate_cycles <= 2) ? 1 : $clog2(gate_cycles);
  endfunction

endpackage

// File: rtl/clk_mon_edge_det.sv
// Any-edge detector for a level signal from another clock domain.
// Two synchronizer flops followed by a history flop; any_edge is high for
// one clk cycle for every rising or falling transition of din.
//   clk      in  1  destination clock
//   rst      in  1  asynchronous, active-high reset
//   din      in  1  asynchronous level input
//   any_edge out 1  one-cycle pulse per transition of din
module clk_mon_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic any_edge
);

  logic sync_p0;
  logic sync_p1;
  logic hist_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      hist_p2 <= 1'b0;
    end else begin
      // p0/p1: metastability filter; p2: previous synchronized level
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      hist_p2 <= sync_p1;
    end
  end

  assign any_edge = sync_p1 ^ hist_p2;

endmodule

// File: rtl/clk_freq_monitor.sv
// Clock-health checker. Counts edges of a toggle flop from a monitored clock
// domain over a window of GATE_CYCLES fabric cycles and checks the count
// against [EXP_MIN, EXP_MAX]. FAULT_LIMIT consecutive bad windows set a
// sticky Fault.
// Optional feature macro: CLK_MON_AUTO_RST_EN -- when defined, Reset_Req
// pulses for one cycle on each rising edge of Fault; otherwise it is tied 0.
//   CLK         in  1   main fabric clock
//   RST         in  1   asynchronous, active-high reset
//   Enable      in  1   run measurements while high
//   Mon_Toggle  in  1   toggle flop from the monitored domain (async)
//   Clear_Fault in  1   single-cycle pulse, clears Fault
//   Count_Value out 16  edge count of the last completed window
//   Count_Valid out 1   one-cycle pulse when Count_Value updates
//   Freq_OK     out 1   last evaluated window was in band
//   Fault       out 1   sticky fault flag
//   Reset_Req   out 1   one-cycle pulse when Fault rises
module clk_freq_monitor
  import clk_mon_pkg::*;
#(
  parameter int GATE_CYCLES = 16000,
  parameter int EXP_MIN     = 7600,
  parameter int EXP_MAX     = 8400,
  parameter int FAULT_LIMIT = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Enable,
  input  logic             Mon_Toggle,
  input  logic             Clear_Fault,
  output logic [CNT_W-1:0] Count_Value,
  output logic             Count_Valid,
  output logic             Freq_OK,
  output logic             Fault,
  output logic             Reset_Req
);

  localparam int               GW        = GATE_W(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(EXP_MAX);
  localparam logic [3:0]       LIMIT     = 4'(FAULT_LIMIT);

  function automatic logic [CNT_W-1:0] edge_acc(input logic [CNT_W-1:0] cnt,
                                                input logic inc);
    if (inc && (cnt != CNT_SAT)) return cnt + CNT_W'(1);
    return cnt;
  endfunction

  function automatic logic [3:0] bad_inc(input logic [3:0] b);
    if (b >= LIMIT) return LIMIT;
    return b + 4'd1;
  endfunction

  state_t           state;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [3:0]       bad_cnt;
  logic             discard;
  logic             edge_pulse;

  logic             eval_live;
  logic             in_band;
  logic [3:0]       bad_next;
  logic             fault_set;

  clk_mon_edge_det u_edge_det (
    .clk      (CLK),
    .rst      (RST),
    .din      (Mon_Toggle),
    .any_edge (edge_pulse)
  );

  // A saturated count is out of band even if EXP_MAX were 0xFFFF.
  assign eval_live = (state == EVAL) && !discard;
  assign in_band   = (edge_cnt >= MIN_C) && (edge_cnt <= MAX_C) &&
                     (edge_cnt != CNT_SAT);
  assign bad_next  = bad_inc(bad_cnt);
  assign fault_set = eval_live && !in_band && (bad_next == LIMIT) && !Fault;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      bad_cnt     <= '0;
      discard     <= 1'b0;
      Count_Value <= '0;
      Count_Valid <= 1'b0;
      Freq_OK     <= 1'b0;
      Fault       <= 1'b0;
    end else begin
      Count_Valid <= 1'b0;

      case (state)
        IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          discard  <= 1'b0;
          if (Enable) state <= SETTLE;
        end

        // SETTLE and MEASURE share the window timing; SETTLE marks its
        // EVAL cycle as a discard so the first result is thrown away.
        SETTLE, MEASURE: begin
          if (!Enable) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            discard  <= 1'b0;
            Freq_OK  <= 1'b0;
          end else begin
            edge_cnt <= edge_acc(edge_cnt, edge_pulse);
            if (gate_cnt == GATE_LAST) begin
              state    <= EVAL;
              gate_cnt <= '0;
              discard  <= (state == SETTLE);
            end else begin
              gate_cnt <= gate_cnt + GW'(1);
            end
          end
        end

        // An edge seen during EVAL opens the next window's count.
        EVAL: begin
          gate_cnt <= '0;
          edge_cnt <= {{(CNT_W-1){1'b0}}, edge_pulse};
          discard  <= 1'b0;
          state    <= Enable ? MEASURE : IDLE;
          if (!discard) begin
            Count_Value <= edge_cnt;
            Count_Valid <= 1'b1;
            Freq_OK     <= in_band;
            bad_cnt     <= in_band ? 4'd0 : bad_next;
          end
        end

        default: state <= IDLE;
      endcase

      // A fault-setting evaluation beats a simultaneous clear.
      if (fault_set) begin
        Fault <= 1'b1;
      end else if (Clear_Fault) begin
        Fault   <= 1'b0;
        bad_cnt <= '0;
      end
    end
  end

`ifdef CLK_MON_AUTO_RST_EN
  logic reset_req;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) reset_req <= 1'b0;
    else     reset_req <= fault_set;
  end

  assign Reset_Req = reset_req;
`else
  assign Reset_Req = 1'b0;
`endif

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Directed bench for clk_freq_monitor with a 100-cycle window, band 45..55
// and a fault limit of 2.
module tb_clk_freq_monitor;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Enable = 1'b0;
  logic        Mon_Toggle = 1'b0;
  logic        Clear_Fault = 1'b0;
  logic [15:0] Count_Value;
  logic        Count_Valid;
  logic        Freq_OK;
  logic        Fault;
  logic        Reset_Req;

  int total = 0;
  int bad = 0;
  int tog_period = 0;
  int tog_cnt = 0;

`ifdef CLK_MON_AUTO_RST_EN
  localparam logic RR_EXP = 1'b1;
`else
  localparam logic RR_EXP = 1'b0;
`endif

  clk_freq_monitor #(
    .GATE_CYCLES (100),
    .EXP_MIN     (45),
    .EXP_MAX     (55),
    .FAULT_LIMIT (2)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Enable      (Enable),
    .Mon_Toggle  (Mon_Toggle),
    .Clear_Fault (Clear_Fault),
    .Count_Value (Count_Value),
    .Count_Valid (Count_Valid),
    .Freq_OK     (Freq_OK),
    .Fault       (Fault),
    .Reset_Req   (Reset_Req)
  );

  always #5 CLK = ~CLK;

  // Monitored-domain toggle flop: flips every tog_period cycles, holds at 0.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (tog_period != 0) begin
        tog_cnt = tog_cnt + 1;
        if (tog_cnt >= tog_period) begin
          Mon_Toggle = ~Mon_Toggle;
          tog_cnt = 0;
        end
      end else begin
        tog_cnt = 0;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Returns the number of rising edges until Count_Valid is seen (or limit).
  task automatic wait_valid(input int limit, output int n);
    n = 0;
    do begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
    end while (!Count_Valid && n < limit);
  endtask

  task automatic do_reset();
    Enable = 1'b0;
    Clear_Fault = 1'b0;
    tog_period = 0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    total++; if (Count_Value !== 16'd0) begin bad++; $display("FAIL reset_cv: got %0d want 0", Count_Value); end
    total++; if (Count_Valid !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", Count_Valid); end
    total++; if (Freq_OK !== 1'b0) begin bad++; $display("FAIL reset_ok: got %b want 0", Freq_OK); end
    total++; if (Fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b want 0", Fault); end
    total++; if (Reset_Req !== 1'b0) begin bad++; $display("FAIL reset_rr: got %b want 0", Reset_Req); end
    do_reset();
  endtask

  task automatic test_nominal();
    int n;
    do_reset();
    tog_period = 2;
    @(posedge CLK); #1; Enable = 1'b1;
    wait_valid(400, n);
    total++; if (n !== 203) begin bad++; $display("FAIL nom_latency: got %0d want 203", n); end
    total++; if (Count_Value < 16'd49 || Count_Value > 16'd51) begin bad++; $display("FAIL nom_count: got %0d want 49..51", Count_Value); end
    total++; if (Freq_OK !== 1'b1) begin bad++; $display("FAIL nom_ok: got %b want 1", Freq_OK); end
    total++; if (Fault !== 1'b0) begin bad++; $display("FAIL nom_fault: got %b want 0", Fault); end
    @(negedge CLK);
    total++; if (Count_Valid !== 1'b0) begin bad++; $display("FAIL nom_pulse: got %b want 0", Count_Valid); end
    wait_valid(300, n);
    total++; if (n !== 100) begin bad++; $display("FAIL nom_period: got %0d want 100", n); end
    total++; if (Freq_OK !== 1'b1) begin bad++; $display("FAIL nom_ok2: got %b want 1", Freq_OK); end
  endtask

  task automatic test_stuck_low();
    int n;
    do_reset();
    @(posedge CLK); #1; Enable = 1'b1;
    wait_valid(400, n);
    total++; if (n !== 203) begin bad++; $display("FAIL stuck_latency: got %0d want 203", n); end
    total++; if (Count_Value !== 16'd0) begin bad++; $display("FAIL stuck_cv1: got %0d want 0", Count_Value); end
    total++; if (Freq_OK !== 1'b0) begin bad++; $display("FAIL stuck_ok1: got %b want 0", Freq_OK); end
    total++; if (Fault !== 1'b0) begin bad++; $display("FAIL stuck_fault1: got %b want 0", Fault); end
    // Clear_Fault lands on the same edge as the fault-setting evaluation.
    repeat (100) @(posedge CLK);
    #1; Clear_Fault = 1'b1;
    @(posedge CLK); #1; Clear_Fault = 1'b0;
    @(negedge CLK);
    total++; if (Count_Valid !== 1'b1) begin bad++; $display("FAIL stuck_vld2: got %b want 1", Count_Valid); end
    total++; if (Count_Value !== 16'd0) begin bad++; $display("FAIL stuck_cv2: got %0d want 0", Count_Value); end
    total++; if (Fault !== 1'b1) begin bad++; $display("FAIL stuck_fault2: got %b want 1", Fault); end
    total++; if (Reset_Req !== RR_EXP) begin bad++; $display("FAIL stuck_rr2: got %b want %b", Reset_Req, RR_EXP); end
    @(negedge CLK);
    total++; if (Reset_Req !== 1'b0) begin bad++; $display("FAIL stuck_rr_pulse: got %b want 0", Reset_Req); end
    wait_valid(300, n);
    total++; if (Fault !== 1'b1) begin bad++; $display("FAIL stuck_fault3: got %b want 1", Fault); end
    total++; if (Reset_Req !== 1'b0) begin bad++; $display("FAIL stuck_rr3: got %b want 0", Reset_Req); end
  endtask

  task automatic test_clear_fault();
    int n;
    do_reset();
    tog_period = 2;
    @(posedge CLK); #1; Enable = 1'b1;
    wait_valid(400, n);
    total++; if (Freq_OK !== 1'b1) begin bad++; $display("FAIL clr_ok0: got %b want 1", Freq_OK); end
    tog_period = 3;
    wait_valid(300, n);
    total++; if (Freq_OK !== 1'b0 || Fault !== 1'b0) begin bad++; $display("FAIL clr_win1: got ok=%b fault=%b want ok=0 fault=0", Freq_OK, Fault); end
    wait_valid(300, n);
    total++; if (Count_Value < 16'd33 || Count_Value > 16'd34) begin bad++; $display("FAIL clr_count: got %0d want 33..34", Count_Value); end
    total++; if (Fault !== 1'b1) begin bad++; $display("FAIL clr_fault_set: got %b want 1", Fault); end
    total++; if (Reset_Req !== RR_EXP) begin bad++; $display("FAIL clr_rr: got %b want %b", Reset_Req, RR_EXP); end
    @(posedge CLK); #1; Clear_Fault = 1'b1;
    @(posedge CLK); #1; Clear_Fault = 1'b0;
    @(negedge CLK);
    total++; if (Fault !== 1'b0) begin bad++; $display("FAIL clr_cleared: got %b want 0", Fault); end
    wait_valid(300, n);
    total++; if (n !== 99) begin bad++; $display("FAIL clr_period: got %0d want 99", n); end
    total++; if (Fault !== 1'b0 || Freq_OK !== 1'b0) begin bad++; $display("FAIL clr_no_refault: got fault=%b ok=%b want fault=0 ok=0", Fault, Freq_OK); end
    wait_valid(300, n);
    total++; if (Fault !== 1'b1) begin bad++; $display("FAIL clr_refault: got %b want 1", Fault); end
    total++; if (Reset_Req !== RR_EXP) begin bad++; $display("FAIL clr_rr2: got %b want %b", Reset_Req, RR_EXP); end
  endtask

  task automatic test_alternate();
    int n;
    logic exp_ok;
    do_reset();
    @(posedge CLK); #1; Enable = 1'b1;
    wait_valid(400, n);
    total++; if (Freq_OK !== 1'b0 || Fault !== 1'b0) begin bad++; $display("FAIL alt_w0: got ok=%b fault=%b want ok=0 fault=0", Freq_OK, Fault); end
    for (int i = 0; i < 4; i++) begin
      exp_ok = ((i % 2) == 0);
      tog_period = exp_ok ? 2 : 0;
      wait_valid(300, n);
      total++; if (n !== 101) begin bad++; $display("FAIL alt_period%0d: got %0d want 101", i, n); end
      total++; if (Freq_OK !== exp_ok) begin bad++; $display("FAIL alt_ok%0d: got %b want %b (count %0d)", i, Freq_OK, exp_ok, Count_Value); end
      total++; if (Fault !== 1'b0) begin bad++; $display("FAIL alt_fault%0d: got %b want 0", i, Fault); end
    end
  endtask

  task automatic test_enable_drop();
    int n;
    int hits;
    logic [15:0] held;
    do_reset();
    tog_period = 2;
    @(posedge CLK); #1; Enable = 1'b1;
    wait_valid(400, n);
    held = Count_Value;
    total++; if (Freq_OK !== 1'b1) begin bad++; $display("FAIL drop_ok_pre: got %b want 1", Freq_OK); end
    repeat (50) @(posedge CLK);
    #1; Enable = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    total++; if (Freq_OK !== 1'b0) begin bad++; $display("FAIL drop_ok: got %b want 0", Freq_OK); end
    total++; if (Count_Value !== held) begin bad++; $display("FAIL drop_cv_held: got %0d want %0d", Count_Value, held); end
    hits = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge CLK);
      if (Count_Valid) hits++;
    end
    total++; if (hits !== 0) begin bad++; $display("FAIL drop_no_valid: got %0d pulses want 0", hits); end
    total++; if (Count_Value !== held) begin bad++; $display("FAIL drop_cv_idle: got %0d want %0d", Count_Value, held); end
    @(posedge CLK); #1; Enable = 1'b1;
    wait_valid(400, n);
    total++; if (n !== 203) begin bad++; $display("FAIL drop_resettle: got %0d want 203", n); end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    tog_period = 0;
    @(posedge CLK); #1; Enable = 1'b1;
    wait_valid(400, n);
    wait_valid(300, n);
    total++; if (Fault !== 1'b1) begin bad++; $display("FAIL ar_fault_pre: got %b want 1", Fault); end
    tog_period = 2;
    repeat (30) @(posedge CLK);
    #3; RST = 1'b1;
    #1;
    total++; if (Fault !== 1'b0) begin bad++; $display("FAIL ar_fault: got %b want 0", Fault); end
    total++; if (Count_Value !== 16'd0) begin bad++; $display("FAIL ar_cv: got %0d want 0", Count_Value); end
    total++; if (Freq_OK !== 1'b0) begin bad++; $display("FAIL ar_ok: got %b want 0", Freq_OK); end
    total++; if (Count_Valid !== 1'b0 || Reset_Req !== 1'b0) begin bad++; $display("FAIL ar_pulses: got vld=%b rr=%b want 0 0", Count_Valid, Reset_Req); end
    repeat (5) @(posedge CLK);
    #1; RST = 1'b0;
    wait_valid(400, n);
    total++; if (n !== 203) begin bad++; $display("FAIL ar_restart: got %0d want 203", n); end
    total++; if (Freq_OK !== 1'b1) begin bad++; $display("FAIL ar_ok_after: got %b want 1", Freq_OK); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stuck_low();
    test_clear_fault();
    test_alternate();
    test_enable_drop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_freq_monitor.md
# clk_freq_monitor

Clock-health checker running in the main fabric domain, downstream of the clock/reset generator. It measures the toggle rate of a monitored clock (HMC or UART clock) over a fixed gate window of `CLK` cycles and checks the count against a min/max band. After a configurable number of consecutive bad windows it raises a sticky fault and, optionally, a reset request back to the reset controller.

## Interface
Parameters:
- GATE_CYCLES, 16000: length of one measurement window in `CLK` cycles (≥4).
- EXP_MIN, 7600: lowest acceptable edge count per window.
- EXP_MAX, 8400: highest acceptable edge count per window.
- FAULT_LIMIT, 3: consecutive bad windows needed to set `Fault` (1..15).

Ports:
- CLK  in  1  main fabric clock.
- RST  in  1  asynchronous, active-high reset.
- Enable  in  1  level; run measurements while high.
- Mon_Toggle  in  1  toggle flop output from the monitored domain, asynchronous to `CLK`.
- Clear_Fault  in  1  single-cycle pulse; clears `Fault`.
- Count_Value  out  16  edge count of the last completed window.
- Count_Valid  out  1  single-cycle pulse when `Count_Value` updates.
- Freq_OK  out  1  last evaluated window was within [EXP_MIN, EXP_MAX].
- Fault  out  1  sticky; FAULT_LIMIT consecutive bad windows seen.
- Reset_Req  out  1  single-cycle pulse when `Fault` rises.

## Operation
- Reset: all outputs 0, FSM in IDLE, gate/edge/bad counters 0.
- `Mon_Toggle` passes through a 2-FF synchronizer plus one history flop. Both rising and falling edges count, one per cycle at most.
- FSM states:
  - IDLE: counters held at 0. Leaves for SETTLE when `Enable`=1.
  - SETTLE: runs one full window and discards the result. No `Count_Valid`. Leaves for MEASURE.
  - MEASURE: gate counter runs 0..GATE_CYCLES-1 and the edge counter accumulates. An edge seen in the cycle where gate=GATE_CYCLES-1 is included. Goes to EVAL after that cycle.
  - EVAL: one cycle. Latches the count, evaluates it, then returns to MEASURE with both counters at 0, or to IDLE if `Enable`=0.
- Edge counter is 16 bits and saturates at 0xFFFF. A saturated window counts as bad.
- Evaluation:
  - Count in band: `Freq_OK`=1 and the bad counter is cleared.
  - Count out of band: `Freq_OK`=0 and the bad counter increments, saturating at FAULT_LIMIT.
  - When the bad counter reaches FAULT_LIMIT and `Fault` is 0: `Fault` is set.
- `Fault` stays at 1 while bad windows continue. It clears only on `Clear_Fault` or `RST`. Clearing it also clears the bad counter.
- `Clear_Fault` in the same cycle as a fault-setting evaluation: the fault wins and `Fault`=1.
- `Enable` dropped mid-window: next cycle goes to IDLE, counters cleared, `Freq_OK`=0, no `Count_Valid`. `Fault` and `Count_Value` are retained. Re-enable starts again at SETTLE.

## Timing
- Synchronizer latency: 3 `CLK` cycles from a `Mon_Toggle` transition to the edge being counted.
- Result outputs update in the cycle after EVAL: `Count_Value`, `Count_Valid` (1 cycle), `Freq_OK`, `Fault` and `Reset_Req` all change together.
- Window period in MEASURE is GATE_CYCLES+1 cycles (EVAL included). Edges arriving during EVAL count toward the next window.
- First `Count_Valid` comes 2·(GATE_CYCLES+1)+1 cycles after `Enable` rises: one SETTLE window, one MEASURE window, then the output register.
- Maximum measurable toggle rate is CLK/2, i.e. `Mon_Toggle` changing at most every other cycle. Faster input aliases, and the monitored domain must pre-divide.

## Configuration
- `CLK_MON_AUTO_RST_EN` defined: `Reset_Req` pulses for one cycle on each 0→1 transition of `Fault`.
- Not defined: `Reset_Req` is tied to 0 and its logic is removed. `Fault` behaviour is unchanged.

## Structure
- Package `clk_mon_pkg` holds:
  - FSM state enum (IDLE, SETTLE, MEASURE, EVAL);
  - `CNT_W`=16 count width and the saturation constant 16'hFFFF;
  - a `GATE_W` function giving clog2(GATE_CYCLES) for the gate counter.
- Sub-module `clk_mon_edge_det`: 2-FF synchronizer, history flop and any-edge pulse output. It is reusable for other cross-domain status bits.

## Test plan
All scenarios use GATE_CYCLES=100, EXP_MIN=45, EXP_MAX=55, FAULT_LIMIT=2, macro defined.
- `Mon_Toggle` flips every 2 `CLK` cycles, `Enable`=1 → first `Count_Valid` at cycle 203 after enable with `Count_Value`=50 (±1), `Freq_OK`=1, `Fault`=0.
- `Mon_Toggle` held at 0 → `Count_Value`=0 and `Freq_OK`=0 in each window. The second bad window sets `Fault`=1 with a single `Reset_Req` pulse in the same cycle.
- Toggle every cycle is not legal input, so use toggle every 2 cycles then switch to every 3 cycles (~33 per window) → windows read 33 or 34, are bad, and `Fault` is set after 2 windows. Pulse `Clear_Fault` → `Fault`=0. The next bad window does not refault; the second one does.
- Alternate good and bad windows → bad counter keeps resetting, `Fault` never asserts.
- Drop `Enable` at gate=50 → no `Count_Valid`, `Freq_OK`=0 next cycle, `Count_Value` held. Re-enable → SETTLE runs before the next valid result.
- Assert `RST` mid-window with `Fault`=1 → all outputs 0 immediately (asynchronous). The FSM stays in IDLE until `RST` deasserts.
